// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide unit: launches mult/multu/div/divu, holds HI/LO,
// and raises the D-stage stall while an MDU result is pending.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        start,
    input  logic [3:0]  hilo_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        md_use_d,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] hilo_out
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state_reg, state_next;
    logic [CW-1:0]  counter_reg, counter_next;
    logic [31:0]    hi_reg, lo_reg, hi_tmp_reg, lo_tmp_reg;
    logic           keep_reg;
    logic           launch, finish, is_md_op, is_div;
    logic [31:0]    res_hi, res_lo;
    logic           res_keep;

    assign is_md_op = (hilo_op >= OP_MULT) && (hilo_op <= OP_DIVU);
    assign is_div   = (hilo_op == OP_DIV) || (hilo_op == OP_DIVU);

    always_comb begin
        state_next   = state_reg;
        counter_next = counter_reg;
        launch       = 1'b0;
        finish       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start && !req && is_md_op) begin
                    launch       = 1'b1;
                    state_next   = RUN;
                    counter_next = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                end
            end
            RUN: begin
                counter_next = counter_reg - 1'b1;
                if (counter_reg == CW'(1)) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Result is computed once at launch; a zero divisor flags "keep HI/LO".
    always_comb begin
        logic signed [63:0] sprod;
        logic        [63:0] uprod;
        logic signed [31:0] sa, sb;
        res_hi   = 32'd0;
        res_lo   = 32'd0;
        res_keep = 1'b0;
        sa       = $signed(rs_val);
        sb       = $signed(rt_val);
        sprod    = 64'(sa) * 64'(sb);
        uprod    = {32'd0, rs_val} * {32'd0, rt_val};
        case (hilo_op)
            OP_MULT:  {res_hi, res_lo} = sprod;
            OP_MULTU: {res_hi, res_lo} = uprod;
            OP_DIV: begin
                if (rt_val == 32'd0) begin
                    res_keep = 1'b1;
                end else if (rs_val == 32'h8000_0000 && rt_val == 32'hFFFF_FFFF) begin
                    res_lo = 32'h8000_0000;
                    res_hi = 32'd0;
                end else begin
                    res_lo = sa / sb;
                    res_hi = sa % sb;
                end
            end
            OP_DIVU: begin
                if (rt_val == 32'd0) begin
                    res_keep = 1'b1;
                end else begin
                    res_lo = rs_val / rt_val;
                    res_hi = rs_val % rt_val;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            counter_reg <= '0;
            hi_reg      <= 32'd0;
            lo_reg      <= 32'd0;
            hi_tmp_reg  <= 32'd0;
            lo_tmp_reg  <= 32'd0;
            keep_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            counter_reg <= counter_next;
            if (launch) begin
                hi_tmp_reg <= res_hi;
                lo_tmp_reg <= res_lo;
                keep_reg   <= res_keep;
            end
            if (finish) begin
                if (!keep_reg) begin
                    hi_reg <= hi_tmp_reg;
                    lo_reg <= lo_tmp_reg;
                end
            end else if (!req && state_reg == IDLE) begin
                if (hilo_op == OP_MTHI) hi_reg <= rs_val;
                if (hilo_op == OP_MTLO) lo_reg <= rs_val;
            end
        end
    end

    assign busy     = (state_reg == RUN);
    assign stall_md = md_use_d & (start | busy);
    assign hi       = hi_reg;
    assign lo       = lo_reg;
    assign hilo_out = (hilo_op == OP_MFHI) ? hi_reg :
                      (hilo_op == OP_MFLO) ? lo_reg : 32'd0;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: latency, arithmetic, stall, req cancellation, reset.
module tb_mdu_ctrl;
    logic        clk = 1'b0;
    logic        reset, req, start, md_use_d;
    logic [3:0]  hilo_op;
    logic [31:0] rs_val, rt_val;
    logic        busy, stall_md;
    logic [31:0] hi, lo, hilo_out;

    int errors = 0;
    int checks = 0;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .req(req), .start(start), .hilo_op(hilo_op),
        .rs_val(rs_val), .rt_val(rt_val), .md_use_d(md_use_d), .busy(busy),
        .stall_md(stall_md), .hi(hi), .lo(lo), .hilo_out(hilo_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 1'b0; hilo_op = 4'd0; req = 1'b0; rs_val = 32'd0; rt_val = 32'd0;
    endtask

    // Launch one op, then count busy cycles (bounded) until completion.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int nbusy);
        start = 1'b1; hilo_op = op; rs_val = a; rt_val = b;
        step();
        idle_inputs();
        nbusy = 0;
        while (busy === 1'b1 && nbusy < 50) begin
            nbusy++;
            step();
        end
    endtask

    task automatic write_hilo(input logic [3:0] op, input logic [31:0] v);
        hilo_op = op; rs_val = v;
        step();
        idle_inputs();
    endtask

    task automatic test_reset();
        reset = 1'b1; md_use_d = 1'b0; idle_inputs();
        repeat (3) step();
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL reset_hilo got=%h/%h exp=0/0", hi, lo); end
        checks++; if (stall_md !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0b exp=0", stall_md); end
        $display("reset: busy=%0b hi=%h lo=%h", busy, hi, lo);
    endtask

    task automatic test_arith(input string name, input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] b, input int exp_n,
                              input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        do_op(op, a, b, n);
        checks++; if (n != exp_n) begin errors++; $display("FAIL %s_busy_cycles got=%0d exp=%0d", name, n, exp_n); end
        checks++; if (hi !== exp_hi) begin errors++; $display("FAIL %s_hi got=%h exp=%h", name, hi, exp_hi); end
        checks++; if (lo !== exp_lo) begin errors++; $display("FAIL %s_lo got=%h exp=%h", name, lo, exp_lo); end
        $display("%s: rs=%h rt=%h busy_cycles=%0d hi=%h lo=%h", name, a, b, n, hi, lo);
    endtask

    task automatic test_mfhi_completion();
        int n;
        start = 1'b1; hilo_op = 4'd1; rs_val = 32'd6; rt_val = 32'd7;
        step();
        idle_inputs();
        n = 0;
        while (busy === 1'b1 && n < 50) begin n++; step(); end
        hilo_op = 4'd6; #1;
        checks++; if (hilo_out !== 32'd42) begin errors++; $display("FAIL mflo_completion got=%h exp=%h", hilo_out, 32'd42); end
        hilo_op = 4'd5; #1;
        checks++; if (hilo_out !== 32'd0) begin errors++; $display("FAIL mfhi_completion got=%h exp=0", hilo_out); end
        $display("mf at completion: cycles=%0d lo=%h", n, lo);
        idle_inputs();
    endtask

    task automatic test_div_zero();
        int n;
        write_hilo(4'd7, 32'h11);
        write_hilo(4'd8, 32'h22);
        do_op(4'd3, 32'd5, 32'd0, n);
        checks++; if (n != 10) begin errors++; $display("FAIL divzero_busy got=%0d exp=10", n); end
        checks++; if (hi !== 32'h11 || lo !== 32'h22) begin errors++; $display("FAIL divzero_keep got=%h/%h exp=11/22", hi, lo); end
        do_op(4'd4, 32'd9, 32'd0, n);
        checks++; if (hi !== 32'h11 || lo !== 32'h22) begin errors++; $display("FAIL divuzero_keep got=%h/%h exp=11/22", hi, lo); end
        $display("div by zero: busy_cycles=%0d hi=%h lo=%h", n, hi, lo);
    endtask

    task automatic test_stall();
        int bad;
        md_use_d = 1'b1;
        start = 1'b1; hilo_op = 4'd1; rs_val = 32'd2; rt_val = 32'd3;
        #1;
        checks++; if (stall_md !== 1'b1) begin errors++; $display("FAIL stall_launch got=%0b exp=1", stall_md); end
        step();
        idle_inputs();
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (stall_md !== 1'b1) bad++;
            step();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL stall_busy low_cycles=%0d exp=0", bad); end
        checks++; if (stall_md !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL stall_complete stall=%0b busy=%0b exp=0/0", stall_md, busy); end
        md_use_d = 1'b0;
        start = 1'b1; hilo_op = 4'd1;
        bad = 0;
        #1; if (stall_md !== 1'b0) bad++;
        step();
        idle_inputs();
        for (int i = 0; i < 6; i++) begin
            if (stall_md !== 1'b0) bad++;
            step();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL stall_no_use high_cycles=%0d exp=0", bad); end
        $display("stall: checked launch, busy and completion cycles");
    endtask

    task automatic test_req();
        logic [31:0] h0, l0;
        int n;
        h0 = hi; l0 = lo;
        req = 1'b1; start = 1'b1; hilo_op = 4'd1; rs_val = 32'd9; rt_val = 32'd9;
        step();
        idle_inputs();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL req_launch_busy got=%0b exp=0", busy); end
        repeat (6) step();
        checks++; if (hi !== h0 || lo !== l0) begin errors++; $display("FAIL req_launch_hilo got=%h/%h exp=%h/%h", hi, lo, h0, l0); end
        req = 1'b1; hilo_op = 4'd7; rs_val = 32'hABCD;
        step();
        idle_inputs();
        checks++; if (hi !== h0) begin errors++; $display("FAIL req_mthi got=%h exp=%h", hi, h0); end
        // divu 100/7 with a req pulse in the third busy cycle
        start = 1'b1; hilo_op = 4'd4; rs_val = 32'd100; rt_val = 32'd7;
        step();
        idle_inputs();
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            n++;
            req = (n == 3);
            step();
        end
        req = 1'b0;
        checks++; if (n != 10) begin errors++; $display("FAIL req_midrun_busy got=%0d exp=10", n); end
        checks++; if (hi !== 32'd2 || lo !== 32'd14) begin errors++; $display("FAIL req_midrun_hilo got=%h/%h exp=2/e", hi, lo); end
        $display("req: midrun busy_cycles=%0d hi=%h lo=%h", n, hi, lo);
    endtask

    task automatic test_busy_writes();
        logic [31:0] h0;
        h0 = hi;
        start = 1'b1; hilo_op = 4'd1; rs_val = 32'd3; rt_val = 32'd3;
        step();
        idle_inputs();
        hilo_op = 4'd7; rs_val = 32'h7777;
        step();
        idle_inputs();
        repeat (6) step();
        checks++; if (hi !== 32'd0 || lo !== 32'd9) begin errors++; $display("FAIL mthi_busy_drop got=%h/%h exp=0/9 (prior hi %h)", hi, lo, h0); end
        $display("mthi while busy: hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_reset_midrun();
        start = 1'b1; hilo_op = 4'd3; rs_val = 32'd100; rt_val = 32'd3;
        step();
        idle_inputs();
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL reset_midrun busy=%0b hi=%h lo=%h exp=0/0/0", busy, hi, lo); end
        repeat (12) step();
        checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL reset_no_late_update got=%h/%h exp=0/0", hi, lo); end
        hilo_op = 4'd6; #1;
        checks++; if (hilo_out !== 32'd0) begin errors++; $display("FAIL mflo_after_reset got=%h exp=0", hilo_out); end
        idle_inputs();
        write_hilo(4'd8, 32'h5A);
        hilo_op = 4'd6; #1;
        checks++; if (hilo_out !== 32'h5A) begin errors++; $display("FAIL mflo_after_mtlo got=%h exp=5a", hilo_out); end
        hilo_op = 4'd12; #1;
        checks++; if (hilo_out !== 32'd0) begin errors++; $display("FAIL hilo_out_op12 got=%h exp=0", hilo_out); end
        idle_inputs();
        $display("reset midrun: hi=%h lo=%h", hi, lo);
    endtask

    initial begin
        test_reset();
        test_arith("mult",     4'd1, 32'hFFFF_FFFE, 32'd3,        5,  32'hFFFF_FFFF, 32'hFFFF_FFFA);
        test_arith("multu",    4'd2, 32'hFFFF_FFFE, 32'd3,        5,  32'h0000_0002, 32'hFFFF_FFFA);
        test_arith("multu_ff", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
        test_arith("div",      4'd3, 32'hFFFF_FFF9, 32'd2,        10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        test_arith("div_negb", 4'd3, 32'd7,         32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
        test_arith("divu",     4'd4, 32'd7,         32'd2,        10, 32'd1,         32'd3);
        test_div_zero();
        test_arith("div_ovf",  4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0,        32'h8000_0000);
        test_mfhi_completion();
        test_stall();
        test_req();
        test_busy_writes();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
